// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch predictor:
//   - cnt_state_e : 2-bit saturating counter states SNT/WNT/WT/ST
//   - entries_legal() : table-size legality check, used by branch_predictor
//     at elaboration time (power of two, 2 or greater)
// -----------------------------------------------------------------------------
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,  // strongly not taken
    WNT = 2'b01,  // weakly not taken
    WT  = 2'b10,  // weakly taken
    ST  = 2'b11   // strongly taken
  } cnt_state_e;

  function automatic bit entries_legal(input int unsigned n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/bp_sat_cnt.sv
// -----------------------------------------------------------------------------
// bp_sat_cnt
// One 2-bit saturating direction counter (one instance per table entry).
// Ports:
//   clk_i      : clock, rising edge
//   rst_n_i    : asynchronous active-low reset, counter resets to WNT
//   inc_i      : step towards ST (saturating)
//   dec_i      : step towards SNT (saturating)
//   load_i     : load load_val_i; has priority over inc_i/dec_i
//   load_val_i : value loaded on load_i
//   cnt_o      : current counter state
// -----------------------------------------------------------------------------
module bp_sat_cnt
  import bp_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       load_i,
  input  logic [1:0] load_val_i,
  output logic [1:0] cnt_o
);

  cnt_state_e cnt_q;
  cnt_state_e cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = cnt_state_e'(load_val_i);
    end else if (inc_i && (cnt_q != ST)) begin
      cnt_d = cnt_state_e'(cnt_q + 2'd1);
    end else if (dec_i && (cnt_q != SNT)) begin
      cnt_d = cnt_state_e'(cnt_q - 2'd1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= WNT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Direct-mapped branch target buffer with a 2-bit saturating direction
// counter per entry. Lookup is combinational (zero latency); updates from
// resolved branches are written at the rising edge and visible the next cycle.
//
// Parameters:
//   ENTRIES : number of table entries (power of two, >= 2)
//   ADDR_W  : PC width in bits
//
// Ports:
//   clk_i, rst_n_i   : clock (rising edge) and asynchronous active-low reset
//   lookup_valid_i   : fetch-stage lookup request
//   lookup_pc_i      : PC being fetched
//   pred_hit_o       : lookup matched a valid entry
//   pred_taken_o     : predict taken
//   pred_target_o    : predicted next PC (entry target, or lookup_pc_i + 4)
//   upd_valid_i      : resolved-branch update request
//   upd_pc_i         : PC of the resolved branch
//   upd_taken_i      : actual outcome
//   upd_target_i     : actual target
//   flush_i          : invalidate the whole table (wins over an update)
//
// Optional feature (macro BP_STATS_EN):
//   upd_mispred_i    : the update being reported was mispredicted
//   stat_updates_o   : saturating count of accepted updates
//   stat_mispred_o   : saturating count of accepted mispredicted updates
//
// Handshake: lookup_valid_i and upd_valid_i are pure qualifiers with no
// ready/back-pressure; the predictor accepts every request in the cycle it
// is presented (an update is only discarded when flush_i is high).
// -----------------------------------------------------------------------------
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              lookup_valid_i,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              flush_i
`ifdef BP_STATS_EN
  ,
  input  logic              upd_mispred_i,
  output logic [31:0]       stat_updates_o,
  output logic [31:0]       stat_mispred_o
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  generate
    if (!entries_legal(ENTRIES)) begin : g_bad_entries
      $error("branch_predictor: ENTRIES must be a power of two >= 2");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Table storage. Only the valid bits (and the counters, inside bp_sat_cnt)
  // are reset; tags and targets are meaningless while valid is clear.
  // ---------------------------------------------------------------------------
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [1:0]         cnt      [ENTRIES];

  // ---------------------------------------------------------------------------
  // Lookup path (combinational, reads the registered table only: no bypass)
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [1:0]       lk_cnt;

  assign lk_idx = lookup_pc_i[IDX_W+1:2];
  assign lk_tag = lookup_pc_i[ADDR_W-1:IDX_W+2];
  assign lk_cnt = cnt[lk_idx];

  assign pred_hit_o    = lookup_valid_i & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
  assign pred_taken_o  = pred_hit_o & lk_cnt[1];
  assign pred_target_o = pred_taken_o ? target_q[lk_idx] : (lookup_pc_i + ADDR_W'(4));

  // ---------------------------------------------------------------------------
  // Update path
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_accept;
  logic             up_alloc;
  logic             up_wr_target;

  assign up_idx       = upd_pc_i[IDX_W+1:2];
  assign up_tag       = upd_pc_i[ADDR_W-1:IDX_W+2];
  assign up_hit       = valid_q[up_idx] & (tag_q[up_idx] == up_tag);
  assign up_accept    = upd_valid_i & ~flush_i;
  // A taken miss evicts whatever occupied the slot.
  assign up_alloc     = up_accept & ~up_hit & upd_taken_i;
  // Taken updates refresh the target whether they hit or allocate.
  assign up_wr_target = up_accept & upd_taken_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (up_alloc) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (up_alloc) begin
      tag_q[up_idx] <= up_tag;
    end
    if (up_wr_target) begin
      target_q[up_idx] <= upd_target_i;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_cnt
      logic sel;
      assign sel = (up_idx == IDX_W'(gi));

      bp_sat_cnt u_cnt (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .inc_i      (up_accept & up_hit & upd_taken_i & sel),
        .dec_i      (up_accept & up_hit & ~upd_taken_i & sel),
        .load_i     (up_alloc & sel),
        .load_val_i (WT),
        .cnt_o      (cnt[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Optional statistics; counted per accepted update, not cleared by flush.
  // ---------------------------------------------------------------------------
`ifdef BP_STATS_EN
  logic [31:0] stat_updates_q;
  logic [31:0] stat_mispred_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stat_updates_q <= '0;
      stat_mispred_q <= '0;
    end else if (up_accept) begin
      if (stat_updates_q != 32'hFFFF_FFFF) begin
        stat_updates_q <= stat_updates_q + 32'd1;
      end
      if (upd_mispred_i && (stat_mispred_q != 32'hFFFF_FFFF)) begin
        stat_mispred_q <= stat_mispred_q + 32'd1;
      end
    end
  end

  assign stat_updates_o = stat_updates_q;
  assign stat_mispred_o = stat_mispred_q;
`endif

  // Byte-offset PC bits and counter bit 0 play no part in lookup decisions.
  logic unused_bits;
  assign unused_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0], lk_cnt[0]};

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model of the predictor table kept in plain arrays.
// Define BP_STATS_EN for both RTL and bench to exercise the statistics ports.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int ADDR_W  = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              lookup_valid;
  logic [ADDR_W-1:0] lookup_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              flush;
  logic              upd_mispred;
`ifdef BP_STATS_EN
  logic [31:0]       stat_updates;
  logic [31:0]       stat_mispred;
`endif

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .lookup_valid_i (lookup_valid),
    .lookup_pc_i    (lookup_pc),
    .pred_hit_o     (pred_hit),
    .pred_taken_o   (pred_taken),
    .pred_target_o  (pred_target),
    .upd_valid_i    (upd_valid),
    .upd_pc_i       (upd_pc),
    .upd_taken_i    (upd_taken),
    .upd_target_i   (upd_target),
    .flush_i        (flush)
`ifdef BP_STATS_EN
    ,
    .upd_mispred_i  (upd_mispred),
    .stat_updates_o (stat_updates),
    .stat_mispred_o (stat_mispred)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int n_compared   = 0;
  int n_mismatched = 0;
  int cycle_no     = 0;
  logic [ADDR_W+1:0] exp_q[$];  // {hit, taken, target}

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s (cycle %0d): got 0x%08h expected 0x%08h", tag, cycle_no, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the table as the specification describes it
  // ---------------------------------------------------------------------------
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_cnt    [ENTRIES];   // 0=SNT 1=WNT 2=WT 3=ST
  logic [31:0] m_updates;
  logic [31:0] m_mispred;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 1;
    end
    m_updates = '0;
    m_mispred = '0;
  endtask

  task automatic model_edge(input bit uv, input logic [31:0] upc, input bit ut,
                            input logic [31:0] utgt, input bit fl, input bit mis);
    int i;
    if (fl) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
    end else if (uv) begin
      i = idx_of(upc);
      if (m_valid[i] && m_tag[i] == tag_of(upc)) begin
        if (ut) begin
          m_cnt[i]    = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
          m_target[i] = utgt;
        end else begin
          m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
        end
      end else if (ut) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = tag_of(upc);
        m_target[i] = utgt;
        m_cnt[i]    = 2;
      end
      if (m_updates != 32'hFFFF_FFFF) m_updates = m_updates + 1;
      if (mis && m_mispred != 32'hFFFF_FFFF) m_mispred = m_mispred + 1;
    end
  endtask

  task automatic model_expect(input bit lv, input logic [31:0] lpc);
    int i;
    bit hit;
    bit tk;
    logic [31:0] tgt;
    i   = idx_of(lpc);
    hit = lv && m_valid[i] && (m_tag[i] == tag_of(lpc));
    tk  = hit && (m_cnt[i] >= 2);
    tgt = tk ? m_target[i] : lpc + 32'd4;
    exp_q.push_back({hit, tk, tgt});
  endtask

  // ---------------------------------------------------------------------------
  // Driver: called at posedge+1; outputs are sampled at the following negedge
  // ---------------------------------------------------------------------------
  task automatic drive_cycle(input bit lv, input logic [31:0] lpc,
                             input bit uv, input logic [31:0] upc, input bit ut,
                             input logic [31:0] utgt, input bit fl, input bit mis);
    logic [ADDR_W+1:0] e;
    lookup_valid = lv;
    lookup_pc    = lpc;
    upd_valid    = uv;
    upd_pc       = upc;
    upd_taken    = ut;
    upd_target   = utgt;
    flush        = fl;
    upd_mispred  = mis;
    @(negedge clk);
    model_expect(lv, lpc);
    e = exp_q.pop_front();
    check_eq("pred_hit",    {31'd0, pred_hit},   {31'd0, e[ADDR_W+1]});
    check_eq("pred_taken",  {31'd0, pred_taken}, {31'd0, e[ADDR_W]});
    check_eq("pred_target", pred_target,         e[ADDR_W-1:0]);
`ifdef BP_STATS_EN
    check_eq("stat_updates", stat_updates, m_updates);
    check_eq("stat_mispred", stat_mispred, m_mispred);
`endif
    @(posedge clk);
    model_edge(uv, upc, ut, utgt, fl, mis);
    cycle_no++;
    #1;
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    drive_cycle(1'b1, pc, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_update(input logic [31:0] pc, input bit tk, input logic [31:0] tgt, input bit mis);
    drive_cycle(1'b0, '0, 1'b1, pc, tk, tgt, 1'b0, mis);
  endtask

  function automatic logic [31:0] rand_pc();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return $urandom() & 32'hFFFF_FFFC;
    if (r == 1) return 32'hFFFF_FFFC - (32'($urandom_range(0, 3)) << 2);
    return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, ENTRIES - 1)) << 2);
  endfunction

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n        = 1'b0;
    lookup_valid = 1'b1;
    lookup_pc    = 32'h40;
    upd_valid    = 1'b0;
    upd_pc       = '0;
    upd_taken    = 1'b0;
    upd_target   = '0;
    flush        = 1'b0;
    upd_mispred  = 1'b0;
    model_reset();

    // Outputs while reset is held
    #12;
    check_eq("rst_hit",    {31'd0, pred_hit},   32'd0);
    check_eq("rst_taken",  {31'd0, pred_taken}, 32'd0);
    check_eq("rst_target", pred_target,         32'h44);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Lookup straight after reset
    do_lookup(32'h40);

    // Three updates, one mispredicted (not-taken misses leave the table alone)
    do_update(32'h1004, 1'b0, 32'h0, 1'b0);
    do_update(32'h1008, 1'b0, 32'h0, 1'b1);
    do_update(32'h100C, 1'b0, 32'h0, 1'b0);
`ifdef BP_STATS_EN
    check_eq("stat_updates_3", stat_updates, 32'd3);
    check_eq("stat_mispred_1", stat_mispred, 32'd1);
`endif

    // Allocate 0x40 with a same-cycle lookup (no bypass), then hit next cycle
    drive_cycle(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
    do_lookup(32'h40);

    // WT -> two not-taken -> SNT
    do_update(32'h40, 1'b0, 32'h0, 1'b1);
    do_update(32'h40, 1'b0, 32'h0, 1'b0);
    do_lookup(32'h40);
    // four taken -> ST, one not-taken -> WT
    for (int k = 0; k < 4; k++) do_update(32'h40, 1'b1, 32'h100, 1'b0);
    do_update(32'h40, 1'b0, 32'h0, 1'b0);
    do_lookup(32'h40);

    // Aliasing at index 0
    do_lookup(32'h80);
    do_update(32'h80, 1'b1, 32'h200, 1'b0);
    do_lookup(32'h80);
    do_lookup(32'h40);

    // Flush wins over a same-cycle update
    drive_cycle(1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h300, 1'b1, 1'b1);
    do_lookup(32'h80);
    do_lookup(32'h40);
    for (int k = 0; k < ENTRIES; k++) do_lookup(32'(k) << 2);
    do_update(32'h80, 1'b1, 32'h240, 1'b0);
    do_lookup(32'h80);

    // Wrap of the fall-through target
    do_lookup(32'hFFFF_FFFC);
    do_update(32'hFFFF_FFFC, 1'b1, 32'h8, 1'b0);
    do_lookup(32'hFFFF_FFFC);
    drive_cycle(1'b0, 32'hFFFF_FFFC, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);

    // Reset asserted mid-operation drops the pending update
    lookup_valid = 1'b1;
    lookup_pc    = 32'h80;
    upd_valid    = 1'b1;
    upd_pc       = 32'h300;
    upd_taken    = 1'b1;
    upd_target   = 32'h500;
    upd_mispred  = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_hit", {31'd0, pred_hit}, 32'd0);
`ifdef BP_STATS_EN
    check_eq("midrst_stat_updates", stat_updates, 32'd0);
    check_eq("midrst_stat_mispred", stat_mispred, 32'd0);
`endif
    model_reset();
    @(negedge clk);
    upd_valid = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;
    do_lookup(32'h300);
    do_lookup(32'h80);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      drive_cycle($urandom_range(0, 3) != 0, rand_pc(),
                  $urandom_range(0, 1) == 1, rand_pc(), $urandom_range(0, 1) == 1,
                  $urandom() & 32'hFFFF_FFFC,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, meaning the number of table entries; legal values are powers of two, 2 or greater.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the PC width in bits.
REQ-003 SHALL derive localparam IDX_W = log2(ENTRIES) and TAG_W = ADDR_W-IDX_W-2.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port lookup_valid_i, input, 1 bit: the IF-stage lookup request.
REQ-007 SHALL have port lookup_pc_i, input, ADDR_W bits: the PC being fetched.
REQ-008 SHALL have port pred_hit_o, output, 1 bit: the lookup matched a valid entry.
REQ-009 SHALL have port pred_taken_o, output, 1 bit: predict taken.
REQ-010 SHALL have port pred_target_o, output, ADDR_W bits: the predicted next PC.
REQ-011 SHALL have port upd_valid_i, input, 1 bit: an ID-stage resolved-branch update.
REQ-012 SHALL have port upd_pc_i, input, ADDR_W bits: the PC of the resolved branch.
REQ-013 SHALL have port upd_taken_i, input, 1 bit: the actual branch outcome.
REQ-014 SHALL have port upd_target_i, input, ADDR_W bits: the actual branch target.
REQ-015 SHALL have port flush_i, input, 1 bit: invalidate the whole table.

Function
REQ-016 SHALL compute the index as pc[IDX_W+1:2] and the tag as pc[ADDR_W-1:IDX_W+2].
REQ-017 SHALL give each entry a valid bit, a TAG_W tag, an ADDR_W target, and a 2-bit saturating counter (SNT=00, WNT=01, WT=10, ST=11).
REQ-018 SHALL make the lookup combinational, with zero latency: pred_hit_o = lookup_valid_i & valid & tag match.
REQ-019 SHALL drive pred_taken_o = pred_hit_o & counter[1].
REQ-020 SHALL drive pred_target_o with the entry target when pred_taken_o=1, else lookup_pc_i+4, wrapping modulo 2^ADDR_W.
REQ-021 SHALL drive pred_hit_o=0 and pred_taken_o=0 when lookup_valid_i=0; pred_target_o is then lookup_pc_i+4.
REQ-022 SHALL, on an update that hits (valid & tag match), increment the counter on taken and decrement it on not-taken, saturating at ST and SNT.
REQ-023 SHALL, on an update that hits with upd_taken_i=1, also overwrite the target.
REQ-024 SHALL, on an update that misses with upd_taken_i=1, allocate the entry (replace any occupant): valid=1, tag, target, counter=WT.
REQ-025 SHALL leave the table unchanged on an update that misses with upd_taken_i=0.
REQ-026 SHALL make an update visible from the next cycle only; a same-cycle lookup of the same index sees the old contents (no bypass).
REQ-027 SHALL have flush_i clear all valid bits at the next edge, leaving counters, tags and targets untouched.
REQ-028 SHALL give flush_i priority over an update in the same cycle; that update is discarded.

Reset
REQ-029 SHALL, while rst_n_i=0, asynchronously clear all valid bits and set all counters to WNT; targets and tags are don't-care.
REQ-030 SHALL output pred_hit_o=0 and pred_taken_o=0 during and immediately after reset.
REQ-031 SHALL, on reset asserted mid-operation, drop any pending update.

Configuration
REQ-032 SHALL provide macro BP_STATS_EN.
REQ-033 SHALL, when BP_STATS_EN is defined, add input upd_mispred_i (1 bit) and outputs stat_updates_o and stat_mispred_o (32 bits each).
REQ-034 SHALL, when BP_STATS_EN is defined, increment stat_updates_o once per accepted update and stat_mispred_o once per update with upd_mispred_i=1.
REQ-035 SHALL make both statistics counters saturate at 0xFFFFFFFF, reset to 0, and not be cleared by flush_i.
REQ-036 SHALL, when BP_STATS_EN is undefined, omit these ports and counters entirely, with all other behaviour identical.

Structure
REQ-037 SHALL place the counter state constants (SNT/WNT/WT/ST) and the ENTRIES legality check in shared package bp_pkg.
REQ-038 SHALL implement the saturating counter as sub-module bp_sat_cnt (2-bit, inc/dec/load inputs), instantiated per entry.

Verification (ENTRIES=16, ADDR_W=32)
REQ-039 SHALL cover: reset, then lookup pc 0x40 -> hit=0, taken=0, target=0x44.
REQ-040 SHALL cover: update 0x40 taken, target 0x100, then next-cycle lookup 0x40 -> hit=1, taken=1, target=0x100; a same-cycle lookup returns hit=0.
REQ-041 SHALL cover: from WT, two not-taken updates at 0x40 -> lookup hit=1, taken=0, target=0x44; four taken updates then one not-taken -> taken=1 (ST saturates to WT).
REQ-042 SHALL cover aliasing: 0x40 allocated, then lookup 0x80 (same index 0, different tag) -> hit=0; taken update 0x80, target 0x200 -> 0x80 hits and 0x40 misses.
REQ-043 SHALL cover: flush_i together with a taken update at 0x80 -> next cycle every lookup has hit=0; a later update allocates normally.
REQ-044 SHALL cover, with BP_STATS_EN: 3 updates of which 1 has mispred=1 -> stat_updates_o=3, stat_mispred_o=1; rst_n_i low mid-run -> both 0 asynchronously.
